// File: rtl/wbm_pkg.sv
// Shared types and constants for the Wishbone burst master.
package wbm_pkg;

   // Master FSM states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2
   } wbm_state_t;

   // Wishbone B4 cycle type identifiers.
   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage

// File: rtl/wbm_ack_timer.sv
// Ack-timeout watchdog: counts consecutive strobe-without-ack cycles and
// flags the cycle that would be the TO_CYC-th one, so the master can leave
// the bus at the very next edge.
module wbm_ack_timer #(
   parameter int TO_CYC = 256
) (
   input  logic sys_clk,
   input  logic RESETN,
   input  logic clr,
   input  logic inc,
   output logic expired
);

   localparam int            CW   = $clog2(TO_CYC + 1);
   localparam logic [CW-1:0] LAST = CW'(TO_CYC - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next count: clear wins over increment; expiry is the counted cycle itself.
   always_comb begin
      cnt_d   = cnt_q;
      expired = 1'b0;
      if (clr) begin
         cnt_d = '0;
      end else if (inc) begin
         cnt_d = cnt_q + CW'(1);
      end
      if (inc && (cnt_q == LAST)) begin
         expired = 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge sys_clk or negedge RESETN) begin
      if (!RESETN) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/wb_burst_master.sv
// Wishbone B4 incrementing-burst master. Commands become one bus cycle each;
// write data streams in with valid/ready, read data streams out valid-only.
// Handshake: a transfer on cmd_* or wd_* happens at a rising edge where
// valid and ready are both high; rd_valid has no ready and must be taken.
module wb_burst_master
   import wbm_pkg::*;
#(
   parameter int dw     = 32,
   parameter int aw     = 32,
   parameter int bl     = 5,
   parameter int TO_CYC = 256
) (
   input  logic            sys_clk,
   input  logic            RESETN,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic            cmd_we,
   input  logic [aw-1:0]   cmd_addr,
   input  logic [bl-1:0]   cmd_len,
   input  logic            wd_valid,
   output logic            wd_ready,
   input  logic [dw-1:0]   wd_data,
   output logic            rd_valid,
   output logic [dw-1:0]   rd_data,
   output logic            done,
   output logic            err,
   output logic            busy,
   output logic            wb_cyc_o,
   output logic            wb_stb_o,
   output logic            wb_we_o,
   output logic [aw-1:0]   wb_addr_o,
   output logic [dw-1:0]   wb_dat_o,
   output logic [dw/8-1:0] wb_sel_o,
   output logic [2:0]      wb_cti_o,
   input  logic            wb_ack_i,
   input  logic [dw-1:0]   wb_dat_i
);

   localparam int            BW         = dw / 8;
   localparam logic [aw-1:0] ADDR_STEP  = aw'(BW);
   localparam logic [aw-1:0] ALIGN_MASK = ~(aw'(BW - 1));
   localparam logic [bl-1:0] ONE_BEAT   = bl'(1);

   wbm_state_t    state_q, state_d;
   logic [aw-1:0] addr_q,  addr_d;
   logic [bl-1:0] beats_q, beats_d;
   logic          we_q,    we_d;
   logic          done_q,  done_d;
   logic          err_q,   err_d;

   logic accept;
   logic beat_ack;
   logic to_expired;

   // Bus and stream outputs decoded from the current state.
   always_comb begin
      cmd_ready = (state_q == IDLE);
      busy      = (state_q != IDLE);
      accept    = cmd_valid & cmd_ready;
      wb_cyc_o  = busy;
      wb_we_o   = busy & we_q;
      wb_sel_o  = busy ? '1 : '0;
      wb_addr_o = addr_q;
      wb_stb_o  = 1'b0;
      wb_dat_o  = '0;
      rd_data   = '0;
      wb_cti_o  = CTI_CLASSIC;
      case (state_q)
         WRITE: begin
            wb_stb_o = wd_valid;
            wb_dat_o = wd_data;
         end
         READ: begin
            wb_stb_o = 1'b1;
            rd_data  = wb_dat_i;
         end
         default: begin
            wb_stb_o = 1'b0;
         end
      endcase
      if (busy) begin
         wb_cti_o = (beats_q > ONE_BEAT) ? CTI_INCR : CTI_EOB;
      end
      // An ack only counts while we are strobing.
      beat_ack = wb_stb_o & wb_ack_i;
      wd_ready = (state_q == WRITE) & beat_ack;
      rd_valid = (state_q == READ) & beat_ack;
      done     = done_q;
      err      = err_q;
   end

   // Next-state and datapath updates.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      beats_d = beats_q;
      we_d    = we_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (cmd_len == '0) begin
                  // Zero-length command completes without touching the bus.
                  done_d = 1'b1;
               end else begin
                  addr_d  = cmd_addr & ALIGN_MASK;
                  beats_d = cmd_len;
                  we_d    = cmd_we;
                  state_d = cmd_we ? WRITE : READ;
               end
            end
         end
         WRITE, READ: begin
            if (beat_ack) begin
               addr_d  = addr_q + ADDR_STEP;
               beats_d = beats_q - ONE_BEAT;
               if (beats_q == ONE_BEAT) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end else if (to_expired) begin
               // Abort: already-transferred beats stay transferred.
               state_d = IDLE;
               err_d   = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge sys_clk or negedge RESETN) begin
      if (!RESETN) begin
         state_q <= IDLE;
         addr_q  <= '0;
         beats_q <= '0;
         we_q    <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         beats_q <= beats_d;
         we_q    <= we_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   wbm_ack_timer #(
      .TO_CYC (TO_CYC)
   ) u_ack_timer (
      .sys_clk (sys_clk),
      .RESETN  (RESETN),
      .clr     ((state_q == IDLE) | beat_ack),
      .inc     (wb_stb_o & ~wb_ack_i),
      .expired (to_expired)
   );

endmodule

// File: tb/tb_wb_burst_master.sv
// Bench for wb_burst_master: a short-timeout instance carries most traffic,
// a second instance with a 16-cycle timeout covers the long-timeout abort.
module tb_wb_burst_master;
   import wbm_pkg::*;

   localparam int TO_MAIN = 4;
   localparam int TO_LONG = 16;

   // ---------------- clock / reset ----------------
   logic sys_clk = 1'b0;
   logic RESETN  = 1'b0;
   always #5 sys_clk = ~sys_clk;

   // ---------------- main instance ----------------
   logic        cmd_valid, cmd_ready, cmd_we;
   logic [31:0] cmd_addr;
   logic [4:0]  cmd_len;
   logic        wd_valid, wd_ready;
   logic [31:0] wd_data;
   logic        rd_valid;
   logic [31:0] rd_data;
   logic        done, err, busy;
   logic        wb_cyc_o, wb_stb_o, wb_we_o;
   logic [31:0] wb_addr_o, wb_dat_o;
   logic [3:0]  wb_sel_o;
   logic [2:0]  wb_cti_o;
   logic        wb_ack_i;
   logic [31:0] wb_dat_i;

   wb_burst_master #(.dw(32), .aw(32), .bl(5), .TO_CYC(TO_MAIN)) dut (
      .sys_clk   (sys_clk),   .RESETN    (RESETN),
      .cmd_valid (cmd_valid), .cmd_ready (cmd_ready),
      .cmd_we    (cmd_we),    .cmd_addr  (cmd_addr),  .cmd_len (cmd_len),
      .wd_valid  (wd_valid),  .wd_ready  (wd_ready),  .wd_data (wd_data),
      .rd_valid  (rd_valid),  .rd_data   (rd_data),
      .done      (done),      .err       (err),       .busy    (busy),
      .wb_cyc_o  (wb_cyc_o),  .wb_stb_o  (wb_stb_o),  .wb_we_o (wb_we_o),
      .wb_addr_o (wb_addr_o), .wb_dat_o  (wb_dat_o),  .wb_sel_o (wb_sel_o),
      .wb_cti_o  (wb_cti_o),  .wb_ack_i  (wb_ack_i),  .wb_dat_i (wb_dat_i)
   );

   // ---------------- long-timeout instance (never acked) ----------------
   logic        c16_valid, c16_ready, c16_wd_ready, c16_rd_valid;
   logic [31:0] c16_rd_data, c16_addr, c16_dat_o;
   logic        c16_done, c16_err, c16_busy, c16_cyc, c16_stb, c16_we;
   logic [3:0]  c16_sel;
   logic [2:0]  c16_cti;

   wb_burst_master #(.dw(32), .aw(32), .bl(5), .TO_CYC(TO_LONG)) dut16 (
      .sys_clk   (sys_clk),     .RESETN    (RESETN),
      .cmd_valid (c16_valid),   .cmd_ready (c16_ready),
      .cmd_we    (1'b0),        .cmd_addr  (32'h0000_0300), .cmd_len (5'd8),
      .wd_valid  (1'b0),        .wd_ready  (c16_wd_ready),  .wd_data (32'h0),
      .rd_valid  (c16_rd_valid), .rd_data  (c16_rd_data),
      .done      (c16_done),    .err       (c16_err),       .busy    (c16_busy),
      .wb_cyc_o  (c16_cyc),     .wb_stb_o  (c16_stb),       .wb_we_o (c16_we),
      .wb_addr_o (c16_addr),    .wb_dat_o  (c16_dat_o),     .wb_sel_o (c16_sel),
      .wb_cti_o  (c16_cti),     .wb_ack_i  (1'b0),          .wb_dat_i (32'h0)
   );

   // ---------------- scoreboard state ----------------
   // Entry: {we, addr[31:0], data[31:0], cti[2:0]}
   logic [67:0] exp_q[$];
   int n_cmp = 0;
   int n_bad = 0;
   int cyc_n = 0;
   int beat_i, done_cnt, err_cnt, done_cyc, err_cyc, last_ack_cyc;
   bit cyc_seen;
   bit mon_en = 1'b1;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Observe the main instance once per cycle, mid-cycle.
   task automatic mon();
      logic [67:0] e;
      if (!mon_en) return;
      if (wb_cyc_o) cyc_seen = 1'b1;
      if (wb_cyc_o && wb_stb_o && wb_ack_i) begin
         chk("beat_expected", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("we",   wb_we_o,   e[67]);
            chk("addr", wb_addr_o, e[66:35]);
            chk("cti",  wb_cti_o,  e[2:0]);
            chk("sel",  wb_sel_o,  4'hF);
            if (e[67]) begin
               chk("wdat",     wb_dat_o, e[34:3]);
               chk("wd_ready", wd_ready, 1);
               chk("rd_valid_w", rd_valid, 0);
            end else begin
               chk("rdat",     rd_data,  e[34:3]);
               chk("rd_valid", rd_valid, 1);
               chk("wd_ready_r", wd_ready, 0);
            end
            beat_i++;
            if (exp_q.size() == 0) last_ack_cyc = cyc_n;
         end
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc_n;
         chk("done_cyc_low", wb_cyc_o, 0);
         chk("done_rdy", cmd_ready, 1);
      end
      if (err) begin
         err_cnt++;
         err_cyc = cyc_n;
         chk("err_cyc_low", wb_cyc_o, 0);
         chk("err_rdy", cmd_ready, 1);
      end
   endtask

   task automatic end_cycle();
      mon();
      @(negedge sys_clk);
      cyc_n++;
   endtask

   task automatic check_reset(input string p);
      chk({p, "_cmd_ready"}, cmd_ready, 1);
      chk({p, "_busy"},      busy,      0);
      chk({p, "_cyc"},       wb_cyc_o,  0);
      chk({p, "_stb"},       wb_stb_o,  0);
      chk({p, "_we"},        wb_we_o,   0);
      chk({p, "_sel"},       wb_sel_o,  0);
      chk({p, "_cti"},       wb_cti_o,  CTI_CLASSIC);
      chk({p, "_addr"},      wb_addr_o, 0);
      chk({p, "_done"},      done,      0);
      chk({p, "_err"},       err,       0);
      chk({p, "_wd_ready"},  wd_ready,  0);
      chk({p, "_rd_valid"},  rd_valid,  0);
   endtask

   // Driver: issue one command and run the slave until done/err.
   // ack_mode: 0 never ack, 1 ack every cycle, 2 random ack with bounded stalls.
   task automatic do_burst(input logic we, input logic [31:0] addr, input logic [4:0] len,
                           input int gap_at, input int gap_len, input int ack_mode,
                           input bit exp_err);
      logic [31:0] a;
      int acc_cyc, gap_cnt, streak;
      a = addr & ~32'h3;
      for (int i = 0; i < int'(len); i++) begin
         exp_q.push_back({we, a, (we ? 32'h0000_00A0 + i : 32'hD000_0000 + i),
                          (i == int'(len) - 1) ? CTI_EOB : CTI_INCR});
         a = a + 32'd4;
      end
      beat_i = 0; done_cnt = 0; err_cnt = 0; cyc_seen = 1'b0;
      done_cyc = -1; err_cyc = -1; last_ack_cyc = -1;
      cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_len = len;
      #1;
      chk("cmd_ready", cmd_ready, 1);
      acc_cyc = cyc_n;
      end_cycle();
      cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
      gap_cnt = 0; streak = 0;
      for (int guard = 0; guard < 64 && done_cnt == 0 && err_cnt == 0; guard++) begin
         wd_valid = 1'b1;
         if (beat_i == gap_at && gap_cnt < gap_len) begin
            wd_valid = 1'b0;
            gap_cnt++;
         end
         wd_data  = 32'h0000_00A0 + beat_i;
         wb_dat_i = 32'hD000_0000 + beat_i;
         case (ack_mode)
            0: wb_ack_i = 1'b0;
            1: wb_ack_i = 1'b1;
            default: wb_ack_i = (streak >= 2) ? 1'b1 : 1'($urandom_range(0, 1));
         endcase
         streak = wb_ack_i ? 0 : streak + 1;
         #1;
         if (guard == 0) begin
            chk("start_cyc",  wb_cyc_o, len != 0);
            chk("start_busy", busy,     len != 0);
         end
         if (we && !wd_valid && len != 0) begin
            chk("gap_stb", wb_stb_o, 0);
            chk("gap_cyc", wb_cyc_o, 1);
         end
         end_cycle();
      end
      wd_valid = 1'b0; wb_ack_i = 1'b0;
      if (exp_err) begin
         chk("to_err_cnt",  err_cnt, 1);
         chk("to_done_cnt", done_cnt, 0);
         chk("to_latency",  err_cyc - acc_cyc, 1 + TO_MAIN);
         exp_q.delete();
      end else begin
         chk("done_cnt", done_cnt, 1);
         chk("err_cnt",  err_cnt,  0);
         chk("sb_left",  exp_q.size(), 0);
         if (len == 0) begin
            chk("len0_done_lat", done_cyc - acc_cyc, 1);
            chk("len0_no_cyc",   cyc_seen, 0);
         end else begin
            chk("done_lat", done_cyc - last_ack_cyc, 1);
         end
         exp_q.delete();
      end
   endtask

   // Global time limit.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // ---------------- main sequence ----------------
   initial begin
      int err_k, d16;
      cmd_valid = 0; cmd_we = 0; cmd_addr = '0; cmd_len = '0;
      wd_valid = 0; wd_data = '0; wb_ack_i = 0; wb_dat_i = '0; c16_valid = 0;
      #12;
      check_reset("por");
      chk("por_c16_rdy", c16_ready, 1);
      @(negedge sys_clk);
      RESETN = 1'b1;
      @(negedge sys_clk);

      do_burst(1'b1, 32'h0000_0100, 5'd4, -1, 0, 1, 1'b0);   // 4-beat write
      do_burst(1'b0, 32'h0000_0200, 5'd1, -1, 0, 1, 1'b0);   // single read
      do_burst(1'b1, 32'h0000_0040, 5'd3,  1, 5, 1, 1'b0);   // write wait states
      do_burst(1'b0, 32'h0000_0300, 5'd8, -1, 0, 0, 1'b1);   // never acked
      do_burst(1'b1, 32'h0000_0080, 5'd0, -1, 0, 1, 1'b0);   // zero length
      do_burst(1'b1, 32'h0000_0103, 5'd2, -1, 0, 1, 1'b0);   // misaligned start
      do_burst(1'b0, 32'hFFFF_FFFC, 5'd2, -1, 0, 1, 1'b0);   // address wrap
      for (int r = 0; r < 6; r++) begin
         do_burst(1'($urandom_range(0, 1)), $urandom,
                  5'($urandom_range(1, 6)), -1, 0, 2, 1'b0);
      end

      // Reset in the middle of beat 3 of an 8-beat read.
      mon_en = 1'b0;
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h0000_0400; cmd_len = 5'd8;
      @(negedge sys_clk);
      cmd_valid = 1'b0; wb_ack_i = 1'b1;
      repeat (2) @(negedge sys_clk);
      #1;
      chk("rst_pre_cyc",  wb_cyc_o,  1);
      chk("rst_pre_addr", wb_addr_o, 32'h0000_0408);
      RESETN = 1'b0;
      #1;
      check_reset("mid");
      wb_ack_i = 1'b0;
      repeat (2) @(negedge sys_clk);
      RESETN = 1'b1;
      exp_q.delete();
      mon_en = 1'b1;
      @(negedge sys_clk);
      do_burst(1'b0, 32'h0000_0500, 5'd2, -1, 0, 1, 1'b0);

      // Long timeout on the second instance.
      c16_valid = 1'b1;
      #1;
      chk("to16_rdy", c16_ready, 1);
      @(negedge sys_clk);
      c16_valid = 1'b0;
      err_k = -1; d16 = 0;
      for (int k = 0; k < 24; k++) begin
         #1;
         if (k == 0) chk("to16_stb", c16_stb, 1);
         if (c16_err && err_k < 0) begin
            err_k = k;
            chk("to16_cyc_low", c16_cyc, 0);
            chk("to16_rdy_after", c16_ready, 1);
         end
         if (c16_done) d16++;
         @(negedge sys_clk);
      end
      chk("to16_latency", err_k, TO_LONG);
      chk("to16_no_done", d16, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/wb_burst_master.md
# wb_burst_master

Wishbone B4 burst master that sits directly upstream of the SDRAM controller's Wishbone slave port. It turns command/data streams into incrementing-burst Wishbone cycles on `sys_clk`. Write data arrives on a valid/ready stream; read data is returned on a valid-only stream. An ack-timeout watchdog aborts a hung cycle.

## Interface
- `dw`, 32: Wishbone data width. Valid values are 32 or 16.
- `aw`, 32: Wishbone byte-address width.
- `bl`, 5: width of the burst-length field. Maximum burst is 2^bl-1 beats.
- `TO_CYC`, 256: number of consecutive un-acked strobe cycles before the cycle is aborted.

Ports (clock and reset first):
- `sys_clk` in 1: single clock.
- `RESETN` in 1: reset, asynchronous and active-low.
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake.
- `cmd_we` in 1: 1 = write, 0 = read.
- `cmd_addr` in aw: start byte address.
- `cmd_len` in bl: number of beats.
- `wd_valid` in 1 / `wd_ready` out 1 / `wd_data` in dw: write-data stream.
- `rd_valid` out 1 / `rd_data` out dw: read-data stream. There is no backpressure.
- `done` out 1: one-cycle pulse when a command completes.
- `err` out 1: one-cycle pulse when a command is aborted by timeout.
- `busy` out 1: high while a command is in progress.
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o` out 1: Wishbone cycle, strobe and write-enable.
- `wb_addr_o` out aw: Wishbone address.
- `wb_dat_o` out dw: Wishbone write data.
- `wb_sel_o` out dw/8: byte selects.
- `wb_cti_o` out 3: cycle type identifier.
- `wb_ack_i` in 1 / `wb_dat_i` in dw: slave acknowledge and read data.

## Operation
- States are IDLE, WRITE and READ.
- `cmd_ready` = (state==IDLE).
- A command is accepted on a rising edge with `cmd_valid & cmd_ready`.
  - `cmd_len`=0: no bus cycle is issued. `done` pulses on the next cycle and the state stays IDLE.
  - Otherwise: latch the address with its low log2(dw/8) bits forced to 0, latch `beats` = `cmd_len`, and go to WRITE or READ according to `cmd_we`.
- In WRITE or READ: `wb_cyc_o`=1, `wb_we_o`=`cmd_we` (registered), `wb_sel_o`=all ones, `busy`=1.
- WRITE state:
  - `wb_stb_o` = `wd_valid`. The master inserts wait states while write data is absent.
  - `wb_dat_o` = `wd_data` (combinational pass-through).
  - `wd_ready` = `wb_ack_i & wb_stb_o`.
- READ state:
  - `wb_stb_o`=1.
  - `rd_valid` = `wb_ack_i & wb_stb_o`, with `rd_data` = `wb_dat_i` (combinational).
- `wb_cti_o`:
  - 3'b010 while `beats` > 1.
  - 3'b111 on the last beat, including single-beat commands.
  - 3'b000 in IDLE.
- On each acked beat: `wb_addr_o` += dw/8 (modulo 2^aw, wrapping silently) and `beats` -= 1.
- On the ack of the last beat: go to IDLE and pulse `done`.
- Timeout:
  - The counter increments on each cycle with `wb_stb_o & !wb_ack_i`.
  - It clears on ack, on command accept, and in IDLE.
  - Write wait states with `wb_stb_o`=0 are not counted.
  - When the counter reaches `TO_CYC`: return to IDLE, pulse `err`, and do not pulse `done`. Beats already transferred are not rolled back.
- An ack arriving in IDLE or while `wb_stb_o`=0 is ignored.

## Timing
- Reset values of all outputs are 0, except `cmd_ready`=1. `wb_cti_o`=3'b000; `wb_addr_o`, `wb_dat_o` and `rd_data` are don't-care zero.
- Assertion of `RESETN` mid-burst drops `wb_cyc_o`/`wb_stb_o` asynchronously. No `done` or `err` is generated.
- Start latency: command accepted at edge N → `wb_cyc_o` high in cycle N+1.
- Last ack sampled at edge M → in cycle M+1, `wb_cyc_o`=0, `done`=1 and `cmd_ready`=1. The earliest next command is accepted at edge M+1.
- Back-to-back acks sustain one beat per clock. `wb_addr_o` and `wb_cti_o` update at the edge where the ack is sampled.
- Timeout: the stb-without-ack cycle numbered `TO_CYC` is the last one. At the following edge `wb_cyc_o` drops and `err` pulses.

## Structure
- `wbm_pkg` contains:
  - the state enum `wbm_state_t` (IDLE, WRITE, READ);
  - the CTI constants `CTI_CLASSIC`=3'b000, `CTI_INCR`=3'b010, `CTI_EOB`=3'b111.
- Sub-module `wbm_ack_timer` holds the timeout counter.
  - Inputs: `sys_clk`, `RESETN`, `clr`, `inc`.
  - Output: `expired`.
  - Parameter: `TO_CYC`.
- All FSM and datapath logic lives in `wb_burst_master`.

## Test plan
- Write, `cmd_addr`=0x100, `cmd_len`=4, data 0xA0..0xA3, slave acks every cycle:
  - addresses 0x100/0x104/0x108/0x10C;
  - `wb_cti_o` 010,010,010,111;
  - `done` exactly 1 cycle after the 4th ack.
- Read, `cmd_addr`=0x200, `cmd_len`=1:
  - single strobe with `wb_cti_o`=111;
  - `rd_valid` on ack with `rd_data`=`wb_dat_i`;
  - `done` follows.
- Write, `cmd_len`=3, `wd_valid` low for 5 cycles before beat 2:
  - `wb_stb_o`=0 while `wb_cyc_o` stays 1;
  - no `err` even with `TO_CYC`=4.
- Read, `cmd_len`=8, slave never acks, `TO_CYC`=16:
  - `err` pulses after 16 un-acked cycles;
  - `wb_cyc_o` drops and `cmd_ready`=1;
  - no `done`.
- `cmd_len`=0:
  - `wb_cyc_o` never asserts;
  - `done` pulses 1 cycle after accept.
- Reset asserted mid-burst on beat 3 of 8:
  - all outputs return to reset values immediately;
  - after release, a new 2-beat read completes normally from its own start address.
